// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state encoding and the default
// 7-bit slave address. Also used by the i2c_master bench.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6
  } i2c_state_e;

  localparam logic [6:0] I2C_SLAVE_ADDR = 7'h50;

endpackage

// File: rtl/i2c_sync_edge.sv
// 2-flop synchronizer plus one history flop for edge detection.
//   clk, rst_n : system clock, async active-low reset (flops reset to 1,
//                which is the idle level of an I2C line)
//   din        : asynchronous pin
//   lvl        : synchronized level
//   rise, fall : one-clk pulses on synchronized edges
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      hist <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      hist <= sync[1];
    end
  end

  assign lvl  = sync[1];
  assign rise = sync[1] & ~hist;
  assign fall = ~sync[1] & hist;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave, 7-bit addressing, no clock stretching.
//   clk, rst_n : system clock, async active-low reset
//   scl        : bus clock from the master (input only)
//   sda        : open-drain data, driven 0 or high-Z
//   rx_data    : last byte written by the master, rx_valid pulses on update
//   tx_data    : byte returned on a read, sampled when tx_req pulses
//   busy       : addressed transaction in progress
//   ack_sent   : pulses each time an ACK is driven
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_SLAVE_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       ack_sent
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_evt, stop_evt;

  i2c_sync_edge u_scl (
    .clk (clk), .rst_n (rst_n), .din (scl),
    .lvl (scl_s), .rise (scl_rise), .fall (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk (clk), .rst_n (rst_n), .din (sda),
    .lvl (sda_s), .rise (sda_rise), .fall (sda_fall)
  );

  assign start_evt = sda_fall & scl_s;
  assign stop_evt  = sda_rise & scl_s;

  i2c_state_e state;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       rw;
  logic       mack;    // master ACKed the byte just sent
  logic       sda_oe;  // 1 = pull sda low

  // Async reset of sda_oe releases the line as soon as rst_n falls.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bitcnt   <= 3'd0;
      shreg    <= 8'h00;
      rw       <= 1'b0;
      mack     <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      ack_sent <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      ack_sent <= 1'b0;
      if (start_evt) begin
        state  <= ADDR;
        bitcnt <= 3'd0;
        sda_oe <= 1'b0;
        // busy survives a repeated START; only IDLE (after NACK) drops it
        if (state == IDLE) busy <= 1'b0;
      end else if (stop_evt) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            shreg  <= {shreg[6:0], sda_s};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (shreg[6:0] == SLAVE_ADDR) begin
                rw    <= sda_s;
                busy  <= 1'b1;
                state <= ADDR_ACK;
              end else begin
                state <= IDLE;
              end
            end
          end
          // First fall starts the ACK clock, second fall ends it.
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe   <= 1'b1;
              ack_sent <= 1'b1;
            end else if (rw) begin
              tx_req <= 1'b1;
              shreg  <= tx_data;
              sda_oe <= ~tx_data[7];
              bitcnt <= 3'd0;
              state  <= RD_DATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= WR_DATA;
            end
          end
          WR_DATA: if (scl_rise) begin
            shreg  <= {shreg[6:0], sda_s};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              rx_data  <= {shreg[6:0], sda_s};
              rx_valid <= 1'b1;
              state    <= WR_ACK;
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe   <= 1'b1;
              ack_sent <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              state  <= WR_DATA;
            end
          end
          RD_DATA: if (scl_fall) begin
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              sda_oe <= 1'b0;
              state  <= RD_ACK;
            end else begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              mack <= ~sda_s;
              if (sda_s) state <= IDLE;
            end else if (scl_fall && mack) begin
              mack   <= 1'b0;
              tx_req <= 1'b1;
              shreg  <= tx_data;
              sda_oe <= ~tx_data[7];
              bitcnt <= 3'd0;
              state  <= RD_DATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;
  localparam int Q = 50;  // quarter SCL period in ns (5 clk)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, ack_sent;
  wire        sda;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk (clk), .rst_n (rst_n), .scl (scl), .sda (sda),
    .rx_data (rx_data), .rx_valid (rx_valid), .tx_data (tx_data),
    .tx_req (tx_req), .busy (busy), .ack_sent (ack_sent)
  );

  int checks = 0;
  int errors = 0;
  int n_rxv = 0, n_txr = 0, n_ack = 0, n_low = 0, n_busy = 0, n_start = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pulse counters and write-data scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        n_rxv++;
        checks++;
        assert (exp_rx.size() > 0 && rx_data === exp_rx[0]) else begin
          errors++;
          $error("FAIL rx_sb observed=%0h expected=%0h", rx_data,
                 exp_rx.size() > 0 ? exp_rx[0] : 8'hxx);
        end
        if (exp_rx.size() > 0) void'(exp_rx.pop_front());
      end
      if (tx_req)   n_txr++;
      if (ack_sent) n_ack++;
      if (busy)     n_busy++;
      if (sda === 1'b0 && !m_oe) n_low++;
      if (dut.start_evt) n_start++;
    end
  end

  task automatic bus_start;
    m_oe = 1'b0; #Q; scl = 1'b1; #Q;
    m_oe = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic bus_stop;
    m_oe = 1'b1; #Q; scl = 1'b1; #Q;
    m_oe = 1'b0; #Q;
  endtask

  task automatic bit_io(input logic b, output logic s);
    m_oe = ~b; #Q; scl = 1'b1; #Q;
    s = sda; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    acked = (s === 1'b0);
  endtask

  // Reads 8 bits, then presents next_tx before the ACK bit so the DUT
  // samples it on the reload.
  task automatic read_byte(input logic m_ack, input logic [7:0] next_tx,
                           output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      b[i] = s;
    end
    tx_data = next_tx;
    bit_io(~m_ack, s);
  endtask

  logic       ak;
  logic [7:0] rb;
  int s_rxv, s_txr, s_ack, s_low, s_busy, s_start;

  task automatic snap;
    s_rxv = n_rxv; s_txr = n_txr; s_ack = n_ack;
    s_low = n_low; s_busy = n_busy; s_start = n_start;
  endtask

  initial begin
    #23;
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_pulses", {rx_valid, tx_req, ack_sent, busy}, 4'b0000);
    chk("rst_sda", sda, 1'b1);
    rst_n = 1'b1;
    #100;

    // Write 0xA5
    snap();
    bus_start();
    write_byte(8'hA0, ak);  chk("wr_addr_ack", ak, 1'b1);
    chk("wr_busy", busy, 1'b1);
    exp_rx.push_back(8'hA5);
    write_byte(8'hA5, ak);  chk("wr_data_ack", ak, 1'b1);
    bus_stop();
    #100;
    chk("wr_rxv_cnt", n_rxv - s_rxv, 1);
    chk("wr_ack_cnt", n_ack - s_ack, 2);
    chk("wr_rx_data", rx_data, 8'hA5);
    chk("wr_busy_end", busy, 1'b0);

    // Read 0x3C then 0xC3, ACK then NACK
    snap();
    tx_data = 8'h3C;
    exp_rd.push_back(8'h3C);
    bus_start();
    write_byte(8'hA1, ak);  chk("rd_addr_ack", ak, 1'b1);
    exp_rd.push_back(8'hC3);
    read_byte(1'b1, 8'hC3, rb);
    chk("rd_byte0", rb, exp_rd.pop_front());
    read_byte(1'b0, 8'h00, rb);
    chk("rd_byte1", rb, exp_rd.pop_front());
    #100;
    chk("rd_txreq_cnt", n_txr - s_txr, 2);
    chk("rd_busy_nack", busy, 1'b1);
    chk("rd_state_idle", dut.state, i2c_pkg::IDLE);
    bus_stop();
    #100;
    chk("rd_busy_end", busy, 1'b0);

    // Address mismatch
    snap();
    bus_start();
    write_byte(8'hA4, ak);  chk("mm_no_ack", ak, 1'b0);
    write_byte(8'h55, ak);  chk("mm_no_ack2", ak, 1'b0);
    bus_stop();
    #100;
    chk("mm_low_cnt", n_low - s_low, 0);
    chk("mm_pulses", (n_rxv - s_rxv) + (n_txr - s_txr) + (n_ack - s_ack), 0);
    chk("mm_busy_cnt", n_busy - s_busy, 0);

    // Repeated START: write 0x12, Sr, read 0x5A
    tx_data = 8'h5A;
    bus_start();
    write_byte(8'hA0, ak);  chk("sr_addr_ack", ak, 1'b1);
    exp_rx.push_back(8'h12);
    write_byte(8'h12, ak);  chk("sr_data_ack", ak, 1'b1);
    bus_start();
    chk("sr_rx_data", rx_data, 8'h12);
    chk("sr_busy_kept", busy, 1'b1);
    exp_rd.push_back(8'h5A);
    write_byte(8'hA1, ak);  chk("sr_rd_ack", ak, 1'b1);
    read_byte(1'b0, 8'h00, rb);
    chk("sr_rd_byte", rb, exp_rd.pop_front());
    bus_stop();
    #100;

    // STOP after 4 data bits
    snap();
    bus_start();
    write_byte(8'hA0, ak);  chk("part_addr_ack", ak, 1'b1);
    for (int i = 0; i < 4; i++) bit_io(1'b1, ak);
    bus_stop();
    #100;
    chk("part_rxv_cnt", n_rxv - s_rxv, 0);
    chk("part_rx_data", rx_data, 8'h12);
    chk("part_busy", busy, 1'b0);

    // SCL held high 20 clk, then one SDA fall
    snap();
    #200;
    m_oe = 1'b1; #Q;
    scl = 1'b0; #Q;
    write_byte(8'hA0, ak);  chk("gl_addr_ack", ak, 1'b1);
    bus_stop();
    #100;
    chk("gl_start_cnt", n_start - s_start, 1);

    // Reset during a read byte (all-zero data keeps sda pulled low)
    tx_data = 8'h00;
    bus_start();
    write_byte(8'hA1, ak);  chk("rr_addr_ack", ak, 1'b1);
    for (int i = 0; i < 4; i++) bit_io(1'b1, ak);
    chk("rr_sda_driven", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rr_sda_release", sda, 1'b1);
    chk("rr_rx_data", rx_data, 8'h00);
    chk("rr_outputs", {rx_valid, tx_req, ack_sent, busy}, 4'b0000);
    #50;
    rst_n = 1'b1;
    #100;
    scl = 1'b1;
    #200;
    chk("rr_state_idle", dut.state, i2c_pkg::IDLE);

    chk("sb_rx_empty", exp_rx.size(), 0);
    chk("sb_rd_empty", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
